mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory among N_PORTS requestors, for example port 0 as instruction fetch and port 1 as data load/store.
- Replaces clock-phase multiplexing of the memory with a valid/ready arbiter on one clock edge.
- Read latency is configurable, and returned data is routed back to the issuing port by a tag pipeline.
- Sits between the pipeline's IF/MEM stages and the Memory block.

Parameters:
- N_PORTS, 2, number of requestor ports (2..8); index 0 has highest fixed priority.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (1..4).
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- req_valid  input  N_PORTS  per-port request valid.
- req_ready  output  N_PORTS  per-port grant; a transfer occurs when valid&ready.
- req_write  input  N_PORTS  per-port write enable (1 = store).
- req_func3  input  3*N_PORTS  per-port access size/sign (LB/LH/LW/LBU/LHU encoding).
- req_addr  input  ADDR_W*N_PORTS  per-port byte address.
- req_wdata  input  DATA_W*N_PORTS  per-port store data.
- resp_valid  output  N_PORTS  one-cycle read-data strobe per port.
- resp_err  output  N_PORTS  one-cycle misalignment error strobe per port.
- resp_rdata  output  DATA_W  read data, shared by all ports; qualified by resp_valid.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_func3  output  3  access size to memory.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_read.

Behaviour:
- Reset (rst=0 at a clk edge):
  - RR pointer = 0; all tag-pipeline valid bits = 0.
  - req_ready, resp_valid and resp_err are all 0 in the cycle after reset.
  - In-flight reads are discarded; no response is produced for them.
- Arbitration is combinational, at most one grant per cycle:
  - Fixed mode: the lowest-index valid port wins.
  - RR mode: the search starts at the pointer and wraps modulo N_PORTS. After a grant to port g the pointer becomes (g+1) mod N_PORTS; with no grant the pointer is unchanged.
  - req_ready[i] = 1 only for the winner and never without req_valid[i].
- Memory drive:
  - The granted request drives mem_* in the same cycle.
  - mem_read = ~write and mem_write = write, both only when the request is aligned.
  - With no grant, mem_read = mem_write = 0 and mem_addr/mem_wdata/mem_func3 = 0.
- Alignment: a halfword access needs addr[0]=0; a word access needs addr[1:0]=0.
  - A misaligned request is accepted (ready=1) but mem_read and mem_write stay 0.
  - A misaligned request still occupies a tag slot.
- Tag pipeline: a MEM_LAT-deep shift register of {valid, err, port_id} is loaded on every accepted read or misaligned access.
  - At the last stage, resp_valid[id]=1 if err=0, or resp_err[id]=1 if err=1.
  - resp_rdata = mem_rdata when the last stage is valid and not an error; otherwise 0.
- Throughput: fully pipelined; one request per cycle; reads from different ports may be outstanding simultaneously.
- Ordering: responses return in issue order.
- Writes complete on acceptance and produce no response; an aligned write never loads a tag.
- Backpressure: no response backpressure; requestors must sample resp_* the cycle it is asserted.
- Fairness: in RR mode, a port held valid is granted within N_PORTS cycles.
- Simultaneous events: a grant and a response for the same port in the same cycle are both honoured.

Decomposition:
- Shared package: F3_Byte/F3_Half/F3_Word/F3_ByteU/F3_HalfU encodings (already in defines.v), tag struct width = 2 + clog2(N_PORTS), and the mode constants ARB_FIXED / ARB_RR.
- One sub-module: rr_arbiter (N-input priority/round-robin grant with pointer register).
- Alignment check and tag pipeline stay in the top module.

Test Plan:
1. RR, N_PORTS=2, MEM_LAT=1: both ports issue reads continuously, port0 to 0x100 and port1 to 0x200 -> grants alternate 0,1,0,1; resp_valid alternates one cycle after each grant with the matching data.
2. Fixed mode: ports 0 and 1 both valid for 4 cycles -> port1 gets no grant until port0 drops valid; then port1 is granted in the next cycle.
3. MEM_LAT=3: reads issued on cycles 0,1,2 from ports 1,0,1 -> resp_valid strobes on cycles 3,4,5 for ports 1,0,1, with data in issue order.
4. LW at 0x102 on port1 -> req_ready=1, mem_read=0; resp_err[1]=1 after MEM_LAT cycles and resp_valid=0. SH at 0x101 -> no mem_write, resp_err asserted.
5. Store 0xDEADBEEF SW to 0x40 from port1, then LW 0x40 from port0 next cycle -> mem_write is a one-cycle pulse; the load returns 0xDEADBEEF and the store produces no response.
6. rst=0 asserted while 2 reads are in flight with MEM_LAT=2 -> no resp_valid after reset; the pointer returns to 0, so port0 is granted first when both ports are valid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings, arbitration modes and tag sizing for the
// memory port arbiter and its round-robin grant sub-block.
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // {valid, err, port_id}
    function automatic int tag_width(input int n_ports);
        return 2 + $clog2(n_ports);
    endfunction

    // func3[2] only selects sign extension, so it does not
    // affect alignment.
    function automatic logic misaligned(
        input logic [2:0] func3,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        case (func3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// N-input grant logic: fixed priority (index 0 first) or round-robin
// with a pointer register. Ports: clk, rst (sync, active-low), valid in,
// one-hot grant out, any (a grant exists), idx (granted port index).
module mem_port_arbiter_rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_RR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         valid,
    output logic [N-1:0]         grant,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // First valid port in search order; RR searches from ptr and wraps.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == ARB_RR) begin
                cand = IDX_W'((int'(ptr) + k) % N);
            end else begin
                cand = IDX_W'(k);
            end
            if (!any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        grant = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (any && MODE == ARB_RR) begin
            ptr <= (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates N requestor ports onto one single-ported memory with a
// tag pipeline that routes read data / alignment errors back.
// Ports: clk, rst (sync, active-low); per-port req_valid/ready/write/
// func3/addr/wdata; per-port resp_valid/resp_err strobes with shared
// resp_rdata; mem_read/write/func3/addr/wdata out, mem_rdata in.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR_MODE = ARB_RR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_valid,
    output logic [N_PORTS-1:0]          req_ready,
    input  logic [N_PORTS-1:0]          req_write,
    input  logic [3*N_PORTS-1:0]        req_func3,
    input  logic [ADDR_W*N_PORTS-1:0]   req_addr,
    input  logic [DATA_W*N_PORTS-1:0]   req_wdata,
    output logic [N_PORTS-1:0]          resp_valid,
    output logic [N_PORTS-1:0]          resp_err,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [2:0]                  mem_func3,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int TAG_W = tag_width(N_PORTS);
    localparam int ID_W  = TAG_W - 2;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [N_PORTS-1:0] grant;
    logic               granted;
    logic [ID_W-1:0]    gidx;
    logic               g_write;
    logic [2:0]         g_func3;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wdata;
    logic               g_misal;
    logic               tag_load;
    tag_t               tags [MEM_LAT];
    tag_t               last;

    mem_port_arbiter_rr_arbiter #(
        .N    (N_PORTS),
        .MODE (RR_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (grant),
        .any   (granted),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign g_write   = req_write[gidx];
    assign g_func3   = req_func3[gidx*3 +: 3];
    assign g_addr    = req_addr[gidx*ADDR_W +: ADDR_W];
    assign g_wdata   = req_wdata[gidx*DATA_W +: DATA_W];
    assign g_misal   = granted && misaligned(g_func3, g_addr[1:0]);

    // Aligned writes finish on acceptance; everything else owes
    // the port a response.
    assign tag_load  = granted && (!g_write || g_misal);

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_func3 = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (granted) begin
            mem_read  = !g_write && !g_misal;
            mem_write = g_write && !g_misal;
            mem_func3 = g_func3;
            mem_addr  = g_addr;
            mem_wdata = g_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= tag_t'{
                valid: tag_load,
                err:   g_misal,
                id:    gidx
            };
            for (int i = 1; i < MEM_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign last = tags[MEM_LAT-1];

    always_comb begin
        resp_valid = '0;
        resp_err   = '0;
        resp_rdata = '0;
        if (last.valid) begin
            if (last.err) begin
                resp_err[last.id] = 1'b1;
            end else begin
                resp_valid[last.id] = 1'b1;
                resp_rdata          = mem_rdata;
            end
        end
    end

endmodule
